// File: rtl/up_counter_5bit_pkg.sv
// ============================================================================
// Module      : up_counter_5bit_pkg
// Description : Shared width, terminal count and count type for the counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package up_counter_5bit_pkg;

  localparam int COUNT_WIDTH = 5;
  localparam int COUNT_MAX   = (1 << COUNT_WIDTH) - 1;

  typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage : up_counter_5bit_pkg

`default_nettype wire

// File: rtl/up_counter_incr.sv
// ============================================================================
// Module      : up_counter_incr
// Description : Combinational WIDTH-bit +1 incrementer as a half-adder ripple.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module up_counter_incr
  import up_counter_5bit_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum
);

  // Carry into bit 0 is the constant +1; the carry out of the MSB is never
  // built, so the result wraps modulo 2^WIDTH.
  logic [WIDTH-1:0] w_carry;

  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i] = a[i] ^ w_carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign w_carry[i+1] = a[i] & w_carry[i];
    end
  end

endmodule : up_counter_incr

`default_nettype wire

// File: rtl/up_counter_5bit.sv
// ============================================================================
// Module      : up_counter_5bit
// Description : Free-running WIDTH-bit up-counter with async active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module up_counter_5bit
  import up_counter_5bit_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             reset
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_incr;

  up_counter_incr #(
    .WIDTH (WIDTH)
  ) u_incr (
    .a   (r_count),
    .sum (w_incr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_incr;
    end
  end

  assign out = r_count;

endmodule : up_counter_5bit

`default_nettype wire

// File: tb/tb_up_counter_5bit.sv
// ============================================================================
// Module      : tb_up_counter_5bit
// Description : Self-checking bench for up_counter_5bit against an edge model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_up_counter_5bit;

  logic       clk;
  logic       reset;
  logic [4:0] out;

  int checks = 0;
  int errors = 0;
  int m      = 0;   // expected count: edges seen out of reset, mod 32

  up_counter_5bit #(
    .WIDTH (5)
  ) dut (
    .out   (out),
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then compare against the model at the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) m = (m + 1) % 32;
    @(negedge clk);
    check(tag, out, 5'(m));
  endtask

  task automatic assert_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    m = 0;
    #1;
    check(tag, out, 5'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic r;

    // Reset at start, before any clock edge
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m = 0;
    #1;
    check("reset_async", out, 5'd0);
    tick("reset_hold");
    tick("reset_hold");

    // Release and count
    reset = 1'b1;
    tick("release_first");
    check("first_edge_one", out, 5'd1);
    for (int i = 0; i < 19; i++) tick("count");
    check("count_20", out, 5'd20);

    // Wrap
    assert_reset("wrap_reset");
    release_reset();
    for (int i = 0; i < 31; i++) tick("wrap_run");
    check("wrap_31", out, 5'd31);
    tick("wrap_edge");
    check("wrap_32_zero", out, 5'd0);
    tick("wrap_edge");
    check("wrap_33_one", out, 5'd1);

    // Long run
    assert_reset("long_reset");
    release_reset();
    for (int i = 0; i < 150; i++) tick("long_run");
    check("long_150", out, 5'd22);

    // Mid-count reset
    assert_reset("mid_reset_pre");
    release_reset();
    for (int i = 0; i < 17; i++) tick("mid_run");
    check("mid_17", out, 5'd17);
    assert_reset("mid_async_clear");
    for (int i = 0; i < 5; i++) tick("mid_hold");
    check("mid_hold_zero", out, 5'd0);
    release_reset();
    tick("mid_release");
    check("mid_release_one", out, 5'd1);

    // Randomized reset/count phases against the model
    for (int i = 0; i < 100; i++) begin
      r = ($urandom_range(0, 7) != 0);
      if (!r) begin
        #2;
        reset = 1'b0;
        m = 0;
        #1;
        check("rand_async", out, 5'd0);
      end else begin
        reset = 1'b1;
      end
      tick("rand_model");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_up_counter_5bit

`default_nettype wire
